xbar_mem_slave: RTL and testbench

Memory-backed slave endpoint that terminates one slave port of the 4x4 crossbar switch. Accepts req/cmd/addr/wdata transactions forwarded by the crossbar, services them from an internal word array after a programmable number of wait states, and returns a single-cycle ack with rdata. Out-of-range accesses are detected, answered with an error pattern and counted, so the crossbar always completes its handshake.

---
 rtl/xbar_pkg.sv | 19 +
 rtl/xbar_sp_ram.sv | 32 +++
 rtl/xbar_mem_slave.sv | 146 ++++++++++++++
 tb/tb_xbar_mem_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: bus widths, port counts, the error read
// pattern and the slave endpoint state type.
package xbar_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int SLAVES_COUNT  = 4;
  localparam int MASTERS_COUNT = 4;

  // Returned for reads that fall outside a slave's word array.
  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } xbar_slv_state_t;

endpackage

// File: rtl/xbar_sp_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_WIDTH, with a registered read.
// Contents are intentionally not reset.
//   clk     : clock, all activity on the rising edge
//   i_we    : write enable (i_wdata -> word i_addr)
//   i_re    : read enable (word i_addr -> o_rdata, registered)
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : read data from the last enabled read; it holds otherwise
module xbar_sp_ram #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/xbar_mem_slave.sv
// Memory-backed endpoint terminating one crossbar slave port. A request is
// captured in IDLE, held for WAIT_STATES cycles, serviced from the word array
// on the edge entering RESP, and answered by a one-cycle registered ack.
// Out-of-range accesses return ERR_PATTERN and are counted in err_cnt.
//   clk     : clock
//   reset   : asynchronous, active-low reset
//   req     : request from crossbar, held until ack
//   addr    : byte address (low SEL_BITS are crossbar select, ignored)
//   cmd     : 1 = write, 0 = read
//   wdata   : write data
//   ack     : one-cycle completion pulse
//   rdata   : read data while ack is high, 0 otherwise
//   err_cnt : saturating count of out-of-range accesses
//
// state | meaning
// IDLE  | waiting for req; captures the request
// WAIT  | burning wait states, counter counts down to 1
// RESP  | array accessed on entry; ack/rdata are registered on exit
module xbar_mem_slave #(
  parameter int ADDRESS_WIDTH = xbar_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = xbar_pkg::DATA_WIDTH,
  parameter int DEPTH         = 256,
  parameter int SEL_BITS      = 2,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic                     cmd,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     ack,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [7:0]               err_cnt
);

  import xbar_pkg::*;

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam int                    HI_LSB   = SEL_BITS + IDX_W;
  localparam logic [3:0]            WS_INIT  = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_PATTERN);

  xbar_slv_state_t       r_state;
  logic [3:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_cmd;
  logic                  r_oor;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [7:0]            r_err_cnt;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_go_resp;
  logic                  w_live;
  logic [IDX_W-1:0]      w_ram_idx;
  logic                  w_ram_cmd;
  logic                  w_ram_oor;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic                  w_unused;

  // Crossbar select bits carry no meaning inside the slave.
  assign w_unused = ^addr[SEL_BITS-1:0];

  assign w_idx = addr[SEL_BITS +: IDX_W];
  assign w_oor = |(addr >> HI_LSB);

  // With zero wait states RESP is entered straight from IDLE, so the array
  // access on that edge must use the live request rather than the capture.
  assign w_go_resp = ((r_state == IDLE) && req && (WAIT_STATES == 0)) ||
                     ((r_state == WAIT) && (r_cnt <= 4'd1));
  assign w_live      = (r_state == IDLE);
  assign w_ram_idx   = w_live ? w_idx : r_idx;
  assign w_ram_cmd   = w_live ? cmd   : r_cmd;
  assign w_ram_oor   = w_live ? w_oor : r_oor;
  assign w_ram_wdata = w_live ? wdata : r_wdata;

  // Gated by reset so a request present while reset is held never commits.
  assign w_ram_we = reset && w_go_resp &&  w_ram_cmd && !w_ram_oor;
  assign w_ram_re = reset && w_go_resp && !w_ram_cmd && !w_ram_oor;

  xbar_sp_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_cmd     <= 1'b0;
      r_oor     <= 1'b0;
      r_wdata   <= '0;
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_rdata <= '0;

      if (w_go_resp && w_ram_oor && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;

      case (r_state)
        IDLE: begin
          if (req) begin
            r_idx   <= w_idx;
            r_cmd   <= cmd;
            r_oor   <= w_oor;
            r_wdata <= wdata;
            r_cnt   <= WS_INIT;
            r_state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= RESP;
        end
        RESP: begin
          r_ack   <= 1'b1;
          r_rdata <= r_cmd ? '0 : (r_oor ? ERR_DATA : w_ram_rdata);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack     = r_ack;
  assign rdata   = r_rdata;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_xbar_mem_slave.sv
module tb_xbar_mem_slave;

  logic        clk;
  logic        reset;
  logic        req_r   [2];
  logic        cmd_r   [2];
  logic [31:0] addr_r  [2];
  logic [31:0] wdata_r [2];
  logic        ack_w   [2];
  logic [31:0] rdata_w [2];
  logic [7:0]  err_w   [2];

  // instance 0: WAIT_STATES=2, instance 1: WAIT_STATES=0
  xbar_mem_slave #(.WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .reset(reset), .req(req_r[0]), .addr(addr_r[0]), .cmd(cmd_r[0]),
    .wdata(wdata_r[0]), .ack(ack_w[0]), .rdata(rdata_w[0]), .err_cnt(err_w[0]));

  xbar_mem_slave #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset), .req(req_r[1]), .addr(addr_r[1]), .cmd(cmd_r[1]),
    .wdata(wdata_r[1]), .ack(ack_w[1]), .rdata(rdata_w[1]), .err_cnt(err_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  logic [31:0] mem_m   [2][256];
  bit          mv_m    [2][256];
  int          err_m   [2];
  bit          pend    [2];
  longint      err_cyc [2];
  longint      ack_cyc [2];
  logic [31:0] exp_d   [2];
  bit          dchk    [2];
  longint      last_k  [2];
  longint      last_ack_cyc [2];
  logic [31:0] last_ack_d   [2];
  logic [31:0] seq_q[$];

  function automatic int ws(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit ea;
      if (pend[i] && cyc >= err_cyc[i]) begin
        pend[i] = 1'b0;
        if (err_m[i] < 255) err_m[i]++;
      end
      ea = (cyc == ack_cyc[i]);
      chk(i == 0 ? "ack_ws2" : "ack_ws0", longint'(ack_w[i]), longint'(ea));
      if (ea && !dchk[i]) begin
        // read of a never-written word: data unknown, only timing is checked
      end else
        chk(i == 0 ? "rdata_ws2" : "rdata_ws0", longint'(rdata_w[i]),
            ea ? longint'(exp_d[i]) : 0);
      chk(i == 0 ? "errcnt_ws2" : "errcnt_ws0", longint'(err_w[i]), longint'(err_m[i]));
      if (ack_w[i]) begin
        last_ack_cyc[i] = cyc;
        last_ack_d[i]   = rdata_w[i];
        if (i == 1) seq_q.push_back(rdata_w[1]);
      end
    end
  end

  task automatic txn(input int i, input bit c, input logic [31:0] a, input logic [31:0] d);
    longint k;
    int idx;
    bit oor;
    req_r[i] = 1'b1; cmd_r[i] = c; addr_r[i] = a; wdata_r[i] = d;
    @(posedge clk); #1;
    k   = cyc;
    idx = int'(a[9:2]);
    oor = (a[31:10] != 22'd0);
    if (oor) begin
      pend[i]    = 1'b1;
      err_cyc[i] = k + ws(i);
      exp_d[i]   = c ? 32'h0 : 32'hDEAD_BEEF;
      dchk[i]    = 1'b1;
    end else if (c) begin
      mem_m[i][idx] = d;
      mv_m[i][idx]  = 1'b1;
      exp_d[i]      = 32'h0;
      dchk[i]       = 1'b1;
    end else begin
      exp_d[i] = mem_m[i][idx];
      dchk[i]  = mv_m[i][idx];
    end
    ack_cyc[i] = k + ws(i) + 1;
    last_k[i]  = k;
    repeat (ws(i) + 1) begin @(posedge clk); #1; end
    req_r[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_r[i]   = 1'b0;
      ack_cyc[i] = -1;
      pend[i]    = 1'b0;
      err_m[i]   = 0;
    end
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic rand_run(input int i);
    logic [31:0] a;
    repeat (200) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      txn(i, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_r[i] = 1'b0; cmd_r[i] = 1'b0; addr_r[i] = '0; wdata_r[i] = '0;
      err_m[i] = 0; pend[i] = 1'b0; ack_cyc[i] = -1; dchk[i] = 1'b0;
      exp_d[i] = '0; last_k[i] = 0; last_ack_cyc[i] = -1; last_ack_d[i] = '0;
      for (int w = 0; w < 256; w++) begin mem_m[i][w] = '0; mv_m[i][w] = 1'b0; end
    end
    reset = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // write word 4, then read it back
    txn(0, 1'b1, 32'h10, 32'hA5A5_0001);
    settle();
    chk("wr_ack_latency", last_ack_cyc[0] - last_k[0], 3);
    chk("wr_rdata", longint'(last_ack_d[0]), 0);
    chk("wr_errcnt", longint'(err_w[0]), 0);
    txn(0, 1'b0, 32'h10, 32'h0);
    settle();
    chk("rd_ack_latency", last_ack_cyc[0] - last_k[0], 3);
    chk("rd_data_word4", longint'(last_ack_d[0]), 32'hA5A5_0001);

    // zero wait states: back-to-back writes then reads of words 0..7
    seq_q.delete();
    for (int w = 0; w < 8; w++) txn(1, 1'b1, 32'(w * 4), 32'(w));
    for (int w = 0; w < 8; w++) txn(1, 1'b0, 32'(w * 4), 32'h0);
    settle();
    chk("b2b_ack_count", longint'(seq_q.size()), 16);
    if (seq_q.size() == 16)
      for (int w = 0; w < 8; w++) chk("b2b_read_data", longint'(seq_q[8 + w]), longint'(w));

    // reset during WAIT of a write to word 5
    txn(0, 1'b1, 32'h14, 32'h1234);
    req_r[0] = 1'b1; cmd_r[0] = 1'b1; addr_r[0] = 32'h14; wdata_r[0] = 32'hBEEF_5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_errcnt", longint'(err_w[0]), 0);
    chk("rst_rdata", longint'(rdata_w[0]), 0);
    txn(0, 1'b0, 32'h14, 32'h0);
    settle();
    chk("rst_word5_kept", longint'(last_ack_d[0]), 32'h1234);

    // out-of-range write must not touch word 2
    txn(0, 1'b1, 32'h08, 32'h2222_0002);
    do_reset();
    txn(0, 1'b1, 32'h1000_0008, 32'hFFFF_FFFF);
    txn(0, 1'b0, 32'h08, 32'h0);
    settle();
    chk("oor_wr_word2", longint'(last_ack_d[0]), 32'h2222_0002);
    chk("oor_wr_errcnt", longint'(err_w[0]), 1);

    // out-of-range read and saturation
    do_reset();
    txn(0, 1'b0, 32'h0000_0400, 32'h0);
    settle();
    chk("oor_rd_data", longint'(last_ack_d[0]), 32'hDEAD_BEEF);
    chk("oor_rd_errcnt", longint'(err_w[0]), 1);
    repeat (299) txn(0, 1'b0, 32'h0000_0400, 32'h0);
    settle();
    chk("errcnt_sat", longint'(err_w[0]), 255);
    txn(0, 1'b1, 32'h8000_0000, 32'h1);
    settle();
    chk("errcnt_stays", longint'(err_w[0]), 255);

    // randomized traffic on both instances
    do_reset();
    fork
      rand_run(0);
      rand_run(1);
    join
    repeat (5) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
